jk_pattern_driver: RTL and testbench

Drives the J/K inputs of an external JK flip-flop so that its Q output reproduces a loaded bit pattern, one bit per clock, and checks the Q feedback against that pattern. It applies the JK excitation table, the inverse of the flip-flop's characteristic equation. Sits opposite the flip_flop_jk cell: this block is the stimulus end, and the flip-flop is the responder.

---
 rtl/jk_pattern_driver.sv | 183 ++++++++++++++++++
 tb/tb_jk_pattern_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/jk_pattern_driver.sv
// jk_pattern_driver
//
// Drives the J/K inputs of an external JK flip-flop so that its Q output
// reproduces a loaded pattern, LSB first, one bit per clock. The block then
// checks the Q feedback against the same pattern.
//
// Configuration macro: JK_TOGGLE_PREF_EN
//   defined     : 0->1 and 1->0 transitions drive J=1, K=1 (toggle fill)
//   not defined : 0->1 drives J=1, K=0 and 1->0 drives J=0, K=1 (set/reset fill)
//   Hold cases always drive J=0, K=0.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-low
//   start     in   load request, sampled only while idle
//   pattern   in   target Q sequence (WIDTH bits), latched when start is accepted
//   q_fb      in   Q of the driven flip-flop
//   J, K      out  registered excitation drive
//   busy      out  high from start acceptance until done
//   done      out  one-cycle pulse on the last compare
//   mismatch  out  sticky compare-failure flag
//   err_count out  saturating count of failed compares
module jk_pattern_driver #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic             q_fb,
    output logic             J,
    output logic             K,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [7:0]       err_count
);

    localparam int unsigned IdxW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              q_model_q, q_model_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    // Two-deep expected-value pipe: stage 1 lines up with the Q that the
    // flip-flop shows two edges after the bit was driven.
    logic              exp_vld0_q, exp_vld0_d;
    logic              exp_bit0_q, exp_bit0_d;
    logic              exp_vld1_q, exp_vld1_d;
    logic              exp_bit1_q, exp_bit1_d;
    logic [1:0]        jk_q, jk_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mismatch_q, mismatch_d;
    logic [7:0]        err_q, err_d;

    // Excitation table: returns {J, K} that moves Q from cur to nxt.
    function automatic logic [1:0] excite(input logic cur, input logic nxt);
        logic [1:0] jk;
        if (cur == nxt) begin
            jk = 2'b00;
        end else begin
`ifdef JK_TOGGLE_PREF_EN
            jk = 2'b11;
`else
            jk = nxt ? 2'b10 : 2'b01;
`endif
        end
        return jk;
    endfunction

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        q_model_d  = q_model_q;
        idx_d      = idx_q;
        exp_vld0_d = 1'b0;
        exp_bit0_d = 1'b0;
        exp_vld1_d = exp_vld0_q;
        exp_bit1_d = exp_bit0_q;
        jk_d       = 2'b00;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mismatch_d = mismatch_q;
        err_d      = err_q;

        if (exp_vld1_q && (q_fb != exp_bit1_q)) begin
            mismatch_d = 1'b1;
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StDrive;
                    shreg_d    = pattern;
                    q_model_d  = q_fb;
                    idx_d      = '0;
                    mismatch_d = 1'b0;
                    err_d      = 8'd0;
                    busy_d     = 1'b1;
                    exp_vld1_d = 1'b0;
                end
            end
            StDrive: begin
                jk_d       = excite(q_model_q, shreg_q[0]);
                q_model_d  = shreg_q[0];
                shreg_d    = shreg_q >> 1;
                exp_vld0_d = 1'b1;
                exp_bit0_d = shreg_q[0];
                if (idx_q == LastIdx) begin
                    state_d = StDrain;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDrain: begin
                // Two cycles: the last two bits are still in the pipe.
                if (idx_q == IdxW'(1)) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            q_model_q  <= 1'b0;
            idx_q      <= '0;
            exp_vld0_q <= 1'b0;
            exp_bit0_q <= 1'b0;
            exp_vld1_q <= 1'b0;
            exp_bit1_q <= 1'b0;
            jk_q       <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            q_model_q  <= q_model_d;
            idx_q      <= idx_d;
            exp_vld0_q <= exp_vld0_d;
            exp_bit0_q <= exp_bit0_d;
            exp_vld1_q <= exp_vld1_d;
            exp_bit1_q <= exp_bit1_d;
            jk_q       <= jk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign J         = jk_q[1];
    assign K         = jk_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign mismatch  = mismatch_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_jk_pattern_driver.sv
// Testbench for jk_pattern_driver (WIDTH=8) with a behavioural JK flip-flop
// closing the Q feedback loop. force_zero replaces q_fb with a stuck-at-0.
module tb_jk_pattern_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic       J, K, busy, done, mismatch;
    logic [7:0] err_count;

    logic q_ff = 1'b0;
    logic ff_clr = 1'b0;
    logic force_zero = 1'b0;
    logic q_fb;

    int n_checks = 0;
    int n_pass = 0;

    assign q_fb = force_zero ? 1'b0 : q_ff;

    always #5 clk = ~clk;

    // Responder JK flip-flop
    always @(posedge clk) begin
        if (ff_clr) begin
            q_ff <= 1'b0;
        end else begin
            case ({J, K})
                2'b01:   q_ff <= 1'b0;
                2'b10:   q_ff <= 1'b1;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end

    jk_pattern_driver #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (pattern),
        .q_fb      (q_fb),
        .J         (J),
        .K         (K),
        .busy      (busy),
        .done      (done),
        .mismatch  (mismatch),
        .err_count (err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a pattern with start high across one edge (edge S).
    task automatic accept(input logic [7:0] pat);
        pattern = pat;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Counts edges after the current point until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (done) break;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    logic [1:0] jk_d0_exp;
    logic       q_exp [8];
    int         n;
    logic       seen_done;

    initial begin
`ifdef JK_TOGGLE_PREF_EN
        jk_d0_exp = 2'b11;
`else
        jk_d0_exp = 2'b10;
`endif
        // Q after edges S+2..S+9 for pattern 8'b1011_0010
        q_exp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset held with start high: everything stays at reset values
        start   = 1'b1;
        pattern = 8'hFF;
        ff_clr  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outs", {19'd0, J, K, busy, done, mismatch, err_count}, 32'd0);
        end
        ff_clr = 1'b0;
        start  = 1'b0;
        rst    = 1'b1;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Normal run, with an ignored start pulse at S+3
        accept(8'b1011_0010);
        check("run_busy", {31'd0, busy}, 32'd1);
        check("run_jk_s", {30'd0, J, K}, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) begin
                start   = 1'b1;
                pattern = 8'h00;
            end
            tick();
            start = 1'b0;
            if (k >= 2 && k <= 9) check("run_q", {31'd0, q_ff}, {31'd0, q_exp[k-2]});
            check("run_done", {31'd0, done}, (k == 10) ? 32'd1 : 32'd0);
        end
        check("run_busy_end", {31'd0, busy}, 32'd0);
        check("run_mismatch", {31'd0, mismatch}, 32'd0);
        check("run_err", {24'd0, err_count}, 32'd0);
        tick();
        check("done_pulse", {31'd0, done}, 32'd0);

        // Excitation: 8'hFF from Q=0
        ff_clr = 1'b1;
        tick();
        ff_clr = 1'b0;
        accept(8'hFF);
        tick();
        check("exc_d0", {30'd0, J, K}, {30'd0, jk_d0_exp});
        for (int i = 1; i < 8; i++) begin
            tick();
            check("exc_hold", {30'd0, J, K}, 32'd0);
        end
        wait_done(n);
        check("exc_lat", n, 32'd2);
        check("exc_err", {24'd0, err_count}, 32'd0);

        // Fault injection: q_fb stuck at 0, pattern 8'hF0
        force_zero = 1'b1;
        tick();
        accept(8'hF0);
        wait_done(n);
        check("flt_lat", n, 32'd10);
        check("flt_err", {24'd0, err_count}, 32'd4);
        check("flt_mismatch", {31'd0, mismatch}, 32'd1);

        // Restart from the done cycle: flags clear on acceptance
        force_zero = 1'b0;
        accept(8'h3C);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_clear", {23'd0, mismatch, err_count}, 32'd0);
        wait_done(n);
        check("rst_lat", n, 32'd10);
        check("rst_err", {23'd0, mismatch, err_count}, 32'd0);

        // Mid-run reset between D_3 and D_4
        accept(8'hA5);
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst", {20'd0, J, K, busy, done, mismatch, err_count}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check("no_done", {31'd0, seen_done}, 32'd0);
        accept(8'h55);
        wait_done(n);
        check("post_lat", n, 32'd10);
        check("post_err", {23'd0, mismatch, err_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
